// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit: lane steering, extension, error and timeout handling
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  // Last counter value still inside the budget; reaching it without completion times out.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_e      state_q;
  logic [9:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        illegal_d;
  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        timeout_hit;

  // Decode the incoming request: legality, alignment, byte enables and replicated store data.
  always_comb begin
    illegal_d  = 1'b0;
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = wdata_i;
    if (we_i) begin
      illegal_d = (funct3_i >= 3'b011);
    end else begin
      illegal_d = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end
    case (funct3_i[1:0])
      2'b01:   misalign_d = addr_i[0];
      2'b10:   misalign_d = (addr_i[1:0] != 2'b00);
      default: misalign_d = 1'b0;
    endcase
    if (we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr_i[1:0];
          wdata_d = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {addr_i[1], 1'b0};
          wdata_d = {2{wdata_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = wdata_i;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_d = {24'h0, byte_sel};
      3'b101:  load_d = {16'h0, half_sel};
      default: load_d = mem_rdata_i;
    endcase
  end

  assign timeout_hit = (cnt_q >= TO_LAST);

  // Access FSM with its datapath registers; grant/rvalid take priority over the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 10'd0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= we_i;
            funct3_q <= funct3_i;
            off_q    <= addr_i[1:0];
            addr_q   <= {addr_i[31:2], 2'b00};
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            cnt_q    <= 10'd0;
            rdata_q  <= 32'h0;
            err_q    <= illegal_d | misalign_d;
            state_q  <= (illegal_d | misalign_d) ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 10'd1;
          if (mem_gnt_i) begin
            state_q <= S_WAIT;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 10'd1;
          if (mem_rvalid_i) begin
            rdata_q <= we_q ? 32'h0 : load_d;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= S_RESP;
          end
        end
        default: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid_o pops one expected {err, rdata}.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got err=%0b rdata=%h, required no response", err_o, rdata_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({err_o, rdata_o} !== e) begin
          n_fail++;
          $display("FAIL rsp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   err_o, rdata_o, e[32], e[31:0]);
        end
      end
    end
  end

  // One access; gd = cycles of withheld grant (>=90 means never), rd = extra cycles before rvalid.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] word, input int gd, input int rd,
                     input logic exp_err, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input int exp_lat);
    int lat;
    bit mem_path;
    mem_path = (exp_lat > 1);
    lat = 0;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    chk("req_ready", {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      mem_gnt_i    = (c == 1 + gd);
      mem_rvalid_i = (c == 2 + gd + rd);
      mem_rdata_i  = (c == 2 + gd + rd) ? word : 32'h0;
      @(negedge clk);
      if (c == 1) begin
        chk("mem_req_c1", {31'h0, mem_req_o}, {31'h0, mem_path});
        if (mem_path) begin
          chk("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
          chk("mem_be", {28'h0, mem_be_o}, {28'h0, exp_be});
          chk("mem_we", {31'h0, mem_we_o}, {31'h0, we});
          if (we) chk("mem_wdata", mem_wdata_o, exp_wd);
        end
      end
      if (gd >= 90) chk("mem_req_hold", {31'h0, mem_req_o}, (c < exp_lat) ? 32'h1 : 32'h0);
      if (rsp_valid_o) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("latency", lat, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
    wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be_o}, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    rst_n = 1'b1;

    // Loads
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0, 3);
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'hFFFFFF80, 4'hF, 32'h0, 3);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'h00000080, 4'hF, 32'h0, 3);
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'h00008012, 4'hF, 32'h0, 3);
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'hFFFF8012, 4'hF, 32'h0, 3);
    run(1'b0, 3'b000, 32'h100, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'h00000056, 4'hF, 32'h0, 3);
    run(1'b0, 3'b001, 32'h100, 32'h0, 32'h80123456, 0, 0, 1'b0, 32'h00003456, 4'hF, 32'h0, 3);
    // Stores
    run(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h12345678, 0, 1, 1'b0, 32'h0, 4'b0010, 32'hA5A5A5A5, 4);
    run(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0, 0, 1'b0, 32'h0, 4'b1100, 32'hBEEFBEEF, 3);
    run(1'b1, 3'b010, 32'h104, 32'h11223344, 32'h0, 1, 0, 1'b0, 32'h0, 4'b1111, 32'h11223344, 4);
    // Illegal / misaligned
    run(1'b1, 3'b010, 32'h102, 32'h55, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    run(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    run(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    run(1'b0, 3'b101, 32'h103, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1);
    // Completion coinciding with the timeout cycle wins
    run(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0, 32'hCAFEF00D, 4'hF, 32'h0, 5);
    run(1'b0, 3'b010, 32'h304, 32'h0, 32'h01020304, 3, 0, 1'b0, 32'h01020304, 4'hF, 32'h0, 6);
    // Timeout with grant withheld, then a late rvalid in IDLE
    run(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 99, 0, 1'b1, 32'h0, 4'hF, 32'h0, 5);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("late_rvalid_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
    chk("late_rvalid_ready", {31'h0, req_ready_o}, 32'h1);

    // Reset in the middle of an access
    req_valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req_before", {31'h0, mem_req_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req_async", {31'h0, mem_req_o}, 32'h0);
    chk("abort_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {31'h0, req_ready_o}, 32'h1);
    chk("abort_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
    @(posedge clk); #1;
    run(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, 32'h0BADF00D, 4'hF, 32'h0, 3);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-to-memory stage of the RV32 core: consumes the ALU result as the effective address, plus rs2 data and funct3, and performs one byte/half/word access on the data-memory request/grant/response port. Handles byte-lane steering, sign/zero extension, misalignment and illegal-funct3 detection, and a bounded-wait timeout. The core holds the instruction with `req_valid_i` until `rsp_valid_o` arrives.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before an error response; range 1..1023.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  core presents an access.
- `req_ready_o`  out  1  unit accepts; high only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  RV32I load/store funct3.
- `addr_i`  in  32  effective address (ALU result).
- `wdata_i`  in  32  store data (rs2).
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rdata_o`  out  32  extended load data; 0 for stores and errors.
- `err_o`  out  1  valid with `rsp_valid_o`: misaligned, illegal funct3 or timeout.
- `mem_req_o`  out  1  memory request.
- `mem_gnt_i`  in  1  memory accepts request.
- `mem_addr_o`  out  32  `{addr[31:2], 2'b00}`.
- `mem_we_o`  out  1  write enable.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_rvalid_i`  in  1  memory response (loads and stores).
- `mem_rdata_i`  in  32  memory read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i`, register `we`, `funct3`, `addr` and `wdata`, and clear the timeout counter. Go to RESP with error if the access is illegal; otherwise go to REQ.
- Illegal loads: funct3 011, 110, 111. Illegal stores: funct3 ≥ 011.
- Misaligned accesses: half (001/101) with `addr[0]`=1; word (010) with `addr[1:0]`≠0.
- REQ: `mem_req_o`=1. Address, `we`, `be` and wdata stay stable until `mem_gnt_i`=1, then go to WAIT. `mem_rvalid_i` is ignored in REQ.
- WAIT: on `mem_rvalid_i`, register the formatted result and go to RESP.
- RESP: `rsp_valid_o`=1 for exactly one cycle, then go to IDLE.
- Byte enables: SB → `4'b0001 << addr[1:0]`; SH → `4'b0011 << {addr[1],1'b0}`; SW → `4'b1111`; all loads → `4'b1111`.
- Store data: SB → `{4{wdata[7:0]}}`; SH → `{2{wdata[15:0]}}`; SW unchanged.
- Load extraction: LB/LBU use `mem_rdata[8*addr[1:0] +: 8]`; LH/LHU use `mem_rdata[16*addr[1] +: 16]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Timeout: the counter increments every cycle in REQ or WAIT. When it reaches `TIMEOUT` with no completion:
  - Drop `mem_req_o`.
  - Go to RESP with `err_o`=1 and `rdata_o`=0.
  - A late `mem_rvalid_i` arriving in IDLE or RESP is ignored.
- If grant and timeout occur in the same cycle, the grant wins and the unit goes to WAIT. The same rule applies to rvalid versus timeout: rvalid wins.

## Timing
- Reset (`rst_ni` low, asynchronous): state = IDLE.
  - `req_ready_o`=1.
  - `rsp_valid_o`, `err_o`, `mem_req_o` and `mem_we_o` = 0.
  - `rdata_o`, `mem_addr_o`, `mem_be_o`, `mem_wdata_o` and the counter = 0.
- Reset mid-access: the FSM aborts immediately. No response is issued, and `mem_req_o` drops asynchronously.
- Accept on edge 0. `mem_req_o` is high in cycle 1.
- Minimum latency: grant in cycle 1, rvalid in cycle 2, `rsp_valid_o` in cycle 3.
- Error path (illegal or misaligned): `rsp_valid_o` in cycle 1 with no memory traffic.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_*_i` to `mem_*_o`.
- A new request can be accepted in the cycle after RESP, so back-to-back accesses have a 4-cycle minimum spacing.

## Test plan
- LW at addr 0x100: grant in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF → `mem_addr_o`=0x100, `mem_be_o`=1111, `rsp_valid_o` in cycle 3, `rdata_o`=0xDEADBEEF, `err_o`=0.
- LB at 0x103 with mem word 0x80123456 → `rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012.
- SB at 0x101 with wdata 0x000000A5 → `mem_be_o`=0010, `mem_wdata_o`=0xA5A5A5A5, `mem_we_o`=1; response has `rdata_o`=0, `err_o`=0.
- SW at 0x102 → `rsp_valid_o` and `err_o`=1 in cycle 1, `mem_req_o` never asserted. Load with funct3 011 → same response.
- `TIMEOUT`=4, grant withheld → `mem_req_o` high for 4 cycles, then `rsp_valid_o` and `err_o`=1. A later `mem_rvalid_i` in IDLE produces no response.
- Hold `mem_gnt_i` low for 3 cycles, then pull `rst_ni` low → `mem_req_o` goes to 0 immediately with no response. After release, `req_ready_o`=1 and a fresh LW completes normally.
